// File: rtl/joy_ser_pkg.sv
// Shared types and the slot ordering for the two-player serial joystick transmitter.
package joy_ser_pkg;

  localparam int NUM_SLOTS = 24;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  // Bit n of the result is the button sent in slot n (MSB = slot 23).
  function automatic logic [NUM_SLOTS-1:0] slot_map(input logic [11:0] j1,
                                                    input logic [11:0] j2);
    return {j1[7], j1[9], j1[11], j1[10],
            j2[7], j2[9], j2[11], j2[10],
            j2[0], j2[1], j2[2],  j2[3], j2[4], j2[5], j2[6], j2[8],
            j1[0], j1[1], j1[2],  j1[3], j1[4], j1[5], j1[6], j1[8]};
  endfunction

endpackage

// File: rtl/joy_ser_sync.sv
// Two-flop synchronizer with an edge-detect stage; resets to the idle-high level.
module joy_sync
  import joy_ser_pkg::*;
(
  input  logic clk12,
  input  logic pll_lckd,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk12 or negedge pll_lckd) begin
    if (!pll_lckd) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep each flop sampling the previous stage's old value.
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/joy_serializer.sv
// Device-side transmitter for the serial joystick link: captures both players and shifts 24 slots.
// Define JOYSER_CASCADE_EN to add ser_in, which fills slots 24+ so two units can daisy-chain.
module joy_serializer
  import joy_ser_pkg::*;
#(
  parameter int LEAD_EDGES = 1
) (
  input  logic        clk12,
  input  logic        pll_lckd,
  input  logic [11:0] joy1_in,
  input  logic [11:0] joy2_in,
  input  logic        joy_clk,
  input  logic        joy_load,
`ifdef JOYSER_CASCADE_EN
  input  logic        ser_in,
`endif
  output logic        joy_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int FCNT_W = $clog2(LEAD_EDGES + NUM_SLOTS + 1);
  localparam logic [FCNT_W-1:0] SLOT_FIRST = FCNT_W'(LEAD_EDGES);
  localparam logic [FCNT_W-1:0] SLOT_LAST  = FCNT_W'(LEAD_EDGES + NUM_SLOTS - 1);
  localparam logic [FCNT_W-1:0] SLOT_END   = FCNT_W'(LEAD_EDGES + NUM_SLOTS);

  state_t                 state, state_next;
  logic [FCNT_W-1:0]      fcnt, fcnt_next, fcnt_inc;
  logic [NUM_SLOTS-1:0]   shadow, shadow_next;
  logic [SLOT_W-1:0]      slot_idx;
  logic                   data_next;
  logic                   done_next;

  logic clk_lvl, clk_rise, clk_fall;
  logic load_lvl, load_rise, load_fall;

  joy_sync u_clk_sync (
    .clk12    (clk12),
    .pll_lckd (pll_lckd),
    .d        (joy_clk),
    .q        (clk_lvl),
    .rise     (clk_rise),
    .fall     (clk_fall)
  );

  joy_sync u_load_sync (
    .clk12    (clk12),
    .pll_lckd (pll_lckd),
    .d        (joy_load),
    .q        (load_lvl),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{clk_lvl, clk_rise, load_fall};

`ifdef JOYSER_CASCADE_EN
  logic ser_lvl, ser_rise, ser_fall;

  joy_sync u_ser_sync (
    .clk12    (clk12),
    .pll_lckd (pll_lckd),
    .d        (ser_in),
    .q        (ser_lvl),
    .rise     (ser_rise),
    .fall     (ser_fall)
  );

  logic unused_ser;
  assign unused_ser = ^{ser_rise, ser_fall};

  // A chained frame runs past slot 23, so the counter free-runs.
  assign fcnt_inc = fcnt + FCNT_W'(1);
`else
  assign fcnt_inc = (fcnt == SLOT_END) ? fcnt : fcnt + FCNT_W'(1);
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_next  = state;
    fcnt_next   = fcnt;
    shadow_next = shadow;
    done_next   = 1'b0;

    // The button pins are asynchronous; the shadow register is their capture stage.
    if (state == LOAD) shadow_next = slot_map(joy1_in, joy2_in);

    if (!load_lvl) begin
      // Load has priority over everything, including a clock edge in the same cycle.
      state_next = LOAD;
      fcnt_next  = '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (load_rise) begin
            state_next = SHIFT;
            fcnt_next  = '0;
          end
        end
        SHIFT: begin
          if (clk_fall) begin
            fcnt_next = fcnt_inc;
            if (fcnt == SLOT_LAST) begin
              done_next = 1'b1;
`ifndef JOYSER_CASCADE_EN
              state_next = DONE;
`endif
            end
          end
        end
        default: ;
      endcase
    end

    slot_idx  = SLOT_W'(fcnt_next - SLOT_FIRST);
    data_next = 1'b1;
    if (state_next == SHIFT) begin
      if (fcnt_next >= SLOT_FIRST && fcnt_next < SLOT_END) begin
        data_next = shadow_next[slot_idx];
      end
`ifdef JOYSER_CASCADE_EN
      else if (fcnt_next >= SLOT_END) begin
        data_next = ser_lvl;
      end
`endif
    end
  end

  // Outputs are registered from next-state values so joy_data never glitches toward the host.
  always_ff @(posedge clk12 or negedge pll_lckd) begin
    if (!pll_lckd) begin
      state      <= IDLE;
      fcnt       <= '0;
      // NOTE: the shadow is a plain register bank, so it is reset to the released-button pattern.
      shadow     <= '1;
      joy_data   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      fcnt       <= fcnt_next;
      shadow     <= shadow_next;
      joy_data   <= data_next;
      busy       <= (state_next == SHIFT);
      frame_done <= done_next;
    end
  end

endmodule

// File: tb/tb_joy_serializer.sv
// Self-checking bench for joy_serializer: table vectors, corner sequences and random frames.
module tb_joy_serializer;
  import joy_ser_pkg::*;

  localparam int HALF = 28;

`ifdef JOYSER_CASCADE_EN
  localparam logic BEYOND = 1'b0;
`else
  localparam logic BEYOND = 1'b1;
`endif

  // Source bit for each slot; slots 8..19 come from player 2, the rest from player 1.
  localparam int SRC_BIT [NUM_SLOTS] = '{8, 6, 5, 4, 3, 2, 1, 0,
                                         8, 6, 5, 4, 3, 2, 1, 0,
                                         10, 11, 9, 7,
                                         10, 11, 9, 7};

  logic        clk12 = 1'b0;
  logic        pll_lckd;
  logic [11:0] joy1_in;
  logic [11:0] joy2_in;
  logic        joy_clk;
  logic        joy_load;
  logic        joy_data;
  logic        busy;
  logic        frame_done;
`ifdef JOYSER_CASCADE_EN
  logic        ser_in;
`endif

  int n_vec    = 0;
  int n_bad    = 0;
  int fd_count = 0;

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [23:0] exp_slots;
  } vec_t;

  vec_t vecs [10];

  joy_serializer #(.LEAD_EDGES(1)) dut (
    .clk12      (clk12),
    .pll_lckd   (pll_lckd),
    .joy1_in    (joy1_in),
    .joy2_in    (joy2_in),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
`ifdef JOYSER_CASCADE_EN
    .ser_in     (ser_in),
`endif
    .joy_data   (joy_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #42 clk12 = ~clk12;

  always @(posedge clk12) if (frame_done) fd_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk12);
  endtask

  function automatic logic [23:0] model_frame(input logic [11:0] j1, input logic [11:0] j2);
    logic [23:0] r;
    logic [11:0] src;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      src  = (s >= 8 && s < 20) ? j2 : j1;
      r[s] = src[SRC_BIT[s]];
    end
    return r;
  endfunction

  function automatic logic exp_bit(input logic [23:0] e, input int slot);
    if (slot < 0) return 1'b1;
    if (slot < NUM_SLOTS) return e[slot];
    return BEYOND;
  endfunction

  // One host frame: load, release, then n_falls joy_clk periods with data checked per slot.
  task automatic run_frame(input logic [11:0] j1, input logic [11:0] j2, input logic [11:0] j1_mid,
                           input int n_falls, input int abort_at, input bit abort_same,
                           input logic [23:0] e, input string tag);
    int   fd0;
    int   slot;
    logic prev_v;
    logic cur_v;
    bit   aborted;
    aborted  = 1'b0;
    joy1_in  = j1;
    joy2_in  = j2;
    joy_clk  = 1'b1;
    joy_load = 1'b0;
    cycles(10);
    joy_clk = 1'b0;
    cycles(20);
    joy_clk = 1'b1;
    cycles(30);
    check({tag, " busy_in_load"}, busy, 0);
    check({tag, " data_in_load"}, joy_data, 1);
    joy_load = 1'b1;
    cycles(8);
    check({tag, " busy_after_release"}, busy, 1);
    check({tag, " data_before_slot0"}, joy_data, 1);
    fd0    = fd_count;
    prev_v = 1'b1;
    for (int k = 1; k <= n_falls && !aborted; k++) begin
      slot  = k - 1;
      cur_v = exp_bit(e, slot);
      if (abort_same && slot == abort_at) begin
        joy_clk  = 1'b0;
        joy_load = 1'b0;
        cycles(3);
        check($sformatf("%s same_edge_data slot%0d", tag, slot), joy_data, 1);
        check($sformatf("%s same_edge_busy slot%0d", tag, slot), busy, 0);
        aborted = 1'b1;
      end else begin
        joy_clk = 1'b0;
        cycles(2);
        check($sformatf("%s hold slot%0d", tag, slot), joy_data, prev_v);
        cycles(1);
        check($sformatf("%s slot%0d", tag, slot), joy_data, cur_v);
        prev_v = cur_v;
        if (k == 1) joy1_in = j1_mid;
        if (slot == abort_at) begin
          joy_load = 1'b0;
          cycles(3);
          check($sformatf("%s abort_data slot%0d", tag, slot), joy_data, 1);
          check($sformatf("%s abort_busy slot%0d", tag, slot), busy, 0);
          aborted = 1'b1;
        end else begin
          cycles(HALF - 3);
          joy_clk = 1'b1;
          cycles(HALF);
        end
      end
    end
    if (aborted) begin
      cycles(60);
      check({tag, " abort_no_done"}, fd_count, fd0);
      check({tag, " abort_busy_late"}, busy, 0);
      joy_clk = 1'b1;
    end else begin
      cycles(4);
      check({tag, " done_once"}, fd_count, fd0 + 1);
`ifdef JOYSER_CASCADE_EN
      check({tag, " busy_after"}, busy, 1);
`else
      check({tag, " busy_after"}, busy, 0);
`endif
      check({tag, " data_after"}, joy_data, BEYOND);
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] rj1;
    logic [11:0] rj2;
    logic [11:0] rmid;

    vecs[0] = '{12'hFFE, 12'h7FF, 24'hFDFF7F};
    vecs[1] = '{12'h000, 12'hFFF, 24'h0FFF00};
    vecs[2] = '{12'hFFF, 12'h000, 24'hF000FF};
    vecs[3] = '{12'hFFF, 12'hFFF, 24'hFFFFFF};
    vecs[4] = '{12'h000, 12'h000, 24'h000000};
    vecs[5] = '{12'h7FF, 12'hEFF, 24'hDFFEFF};
    vecs[6] = '{12'hEFF, 12'hF7F, 24'hF7FFFE};
    vecs[7] = '{12'hBFF, 12'hDFF, 24'hEBFFFF};
    vecs[8] = '{12'hFBF, 12'hFFD, 24'hFFBFFD};
    vecs[9] = '{12'hD7F, 12'hBFE, 24'h3E7FFF};

    pll_lckd = 1'b0;
    joy1_in  = 12'hFFF;
    joy2_in  = 12'hFFF;
    joy_clk  = 1'b1;
    joy_load = 1'b1;
`ifdef JOYSER_CASCADE_EN
    ser_in   = 1'b0;
`endif

    // Reset held with the host clock running.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk12);
      joy_clk = ~joy_clk;
      cycles(5);
      check($sformatf("reset data %0d", i), joy_data, 1);
      check($sformatf("reset busy %0d", i), busy, 0);
    end
    check("reset no_done", fd_count, 0);
    joy_clk  = 1'b1;
    cycles(2);
    pll_lckd = 1'b1;
    cycles(4);

    // Clock edges in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      joy_clk = 1'b0;
      cycles(HALF);
      joy_clk = 1'b1;
      cycles(HALF);
      check($sformatf("idle data %0d", i), joy_data, 1);
      check($sformatf("idle busy %0d", i), busy, 0);
    end
    check("idle no_done", fd_count, 0);

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].j1, vecs[v].j2, vecs[v].j1, 25, -1, 1'b0, vecs[v].exp_slots,
                $sformatf("vec%0d", v));
    end

    // Extra clocks beyond the frame; the counter saturates and frame_done pulses once.
    run_frame(12'hFFE, 12'h7FF, 12'hFFE, 30, -1, 1'b0, 24'hFDFF7F, "extra30");

    // Inputs change after the first shift edge; the current frame keeps the captured values.
    run_frame(12'hFFE, 12'h7FF, 12'h000, 25, -1, 1'b0, 24'hFDFF7F, "freeze");
    run_frame(12'h000, 12'h7FF, 12'h000, 25, -1, 1'b0, 24'h0DFF00, "after_freeze");

    // Load asserted mid-frame at slot 10, then a full frame.
    run_frame(12'hFFF, 12'h000, 12'hFFF, 25, 10, 1'b0, 24'hF000FF, "abort10");
    run_frame(12'hFFF, 12'h000, 12'hFFF, 25, -1, 1'b0, 24'hF000FF, "post_abort");

    // Load and clock falling together: load wins.
    run_frame(12'h000, 12'h000, 12'h000, 25, 5, 1'b1, 24'h000000, "same_edge");
    run_frame(12'h000, 12'h000, 12'h000, 25, -1, 1'b0, 24'h000000, "post_same");

    for (int r = 0; r < 6; r++) begin
      rj1  = 12'($urandom);
      rj2  = 12'($urandom);
      rmid = 12'($urandom);
      run_frame(rj1, rj2, rmid, 25 + $urandom_range(0, 5), -1, 1'b0, model_frame(rj1, rj2),
                $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/joy_serializer.md
Name: joy_serializer

Overview:
- Device-side transmitter for the two-player serial joystick link (JOY_CLK / JOY_LOAD / JOY_DATA).
- Captures two 12-bit active-low button vectors, then shifts them out one bit per host JOY_CLK in the fixed 24-slot order that the host decoder expects.
- Instantiated on the JAMMA/adapter side, or in the bench as the stimulus model for the top-level joystick reader.

Parameters:
- LEAD_EDGES, 1, number of joy_clk falling edges after load release before slot 0 is driven.
- NUM_SLOTS, 24, data slots per frame (package constant; not to be overridden).

Ports:
- clk12  in  1  system clock, 12 MHz.
- pll_lckd  in  1  asynchronous active-low reset (low until PLL locked).
- joy1_in  in  12  player-1 buttons, active-low, asynchronous to clk12.
- joy2_in  in  12  player-2 buttons, active-low, asynchronous to clk12.
- joy_clk  in  1  host shift clock, asynchronous.
- joy_load  in  1  host load strobe, active-low, asynchronous.
- joy_data  out  1  serial data to host; idle level 1.
- busy  out  1  high while in SHIFT.
- frame_done  out  1  one-cycle pulse after the last slot is driven.

Behaviour:
- Reset (pll_lckd=0): state IDLE, joy_data=1, busy=0, frame_done=0, shadow=24'hFFFFFF, edge counter=0.
- Input sampling: joy_clk and joy_load each pass through a 2-FF synchronizer plus one edge-detect register.
  - joy_data changes exactly 3 clk12 cycles after a joy_clk pin falling edge.
  - joy_clk high and low phases must each last at least 4 clk12 cycles.
- States:
  - IDLE: joy_data=1. Synced load low -> LOAD.
  - LOAD: shadow is reloaded every cycle from the slot-mapped inputs; joy_data=1.
    - Synced load rising edge -> SHIFT with fcnt=0. The shadow is frozen at that edge.
  - SHIFT: each synced joy_clk falling edge increments fcnt. slot = fcnt - LEAD_EDGES.
    - joy_data = shadow[slot] while 0 <= slot < 24; otherwise joy_data=1.
    - When slot 23 has been driven for one falling-edge interval (the next falling edge), pulse frame_done and go to DONE.
  - DONE: joy_data=1. Synced load low -> LOAD.
- Slot map (slot:source):
  - 0:j1[8], 1:j1[6], 2:j1[5], 3:j1[4], 4:j1[3], 5:j1[2], 6:j1[1], 7:j1[0]
  - 8:j2[8], 9:j2[6], 10:j2[5], 11:j2[4], 12:j2[3], 13:j2[2], 14:j2[1], 15:j2[0]
  - 16:j2[10], 17:j2[11], 18:j2[9], 19:j2[7]
  - 20:j1[10], 21:j1[11], 22:j1[9], 23:j1[7]
- Boundaries:
  - Load low in any state, including mid-SHIFT: abort immediately to LOAD, joy_data=1, busy=0, no frame_done.
  - Load edge and clk edge in the same cycle: load wins.
  - joy_clk edges in IDLE, LOAD or DONE are ignored.
  - fcnt saturates at LEAD_EDGES+NUM_SLOTS.
  - Inputs changing during SHIFT do not affect the current frame.
- Width: fcnt is 5 bits for the default parameters, sized as $clog2(LEAD_EDGES+NUM_SLOTS+1).

Optional Feature:
- Macro: JOYSER_CASCADE_EN.
- Defined:
  - Adds input port ser_in (1 bit), passed through its own 2-FF synchronizer.
  - In SHIFT, slots 24 and beyond output the synchronized ser_in instead of 1, so two units can daisy-chain like a 74HC165 chain.
  - fcnt saturation is removed; it wraps only at its width limit.
  - frame_done still pulses after slot 23.
- Not defined: no ser_in port; behaviour exactly as above.

Decomposition:
- Package joy_ser_pkg contains:
  - constant NUM_SLOTS=24;
  - state enum {IDLE, LOAD, SHIFT, DONE};
  - function slot_map(j1, j2) returning the 24-bit shadow in slot order.
- Sub-module joy_sync: 2-FF synchronizer plus rise/fall pulse outputs, clocked by clk12, reset by pll_lckd to 1. Instantiated for joy_clk and joy_load, and for ser_in when the cascade macro is defined.

Test Plan:
- Reset: hold pll_lckd=0 with joy_clk toggling -> joy_data=1, busy=0, frame_done never asserted.
- Nominal frame at 212 kHz joy_clk:
  - Stimulus: joy1_in=12'hFFE, joy2_in=12'h7FF; load low for one period, then release.
  - Required: slots 0–23 read 1 except slot 7=0 (j1[0]) and slot 17=0 (j2[11]); frame_done pulses once; joy_data=1 afterwards.
- Input freeze: change joy1_in to 12'h000 after the first SHIFT edge -> current frame unchanged; next frame reads all j1 slots as 0.
- Abort: assert load at slot 10 -> joy_data=1 within 3 cycles, busy=0, no frame_done; the following full frame is correct.
- Extra clocks: 30 falling edges after release -> slots 24–29 read 1, fcnt saturates, frame_done pulses exactly once.
- JOYSER_CASCADE_EN with ser_in held 0 -> slots 24–29 read 0, slots 0–23 unchanged.
